vga_640x480_timing: RTL and testbench
=====================================

# vga_640x480_timing

Generates the 640x480@60 Hz VGA raster timing that drives the pattern and pixel generators. The block divides the system clock down to the pixel rate and runs horizontal and vertical counters. It produces `hsync`, `vsync`, the video-on window `vidon`, and the raw counter values `hc`/`vc` that downstream colour logic decodes. It sits between the board clock and every colour-generating block, and is the source end of the `hc`/`vc`/`vidon` interface.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; must be ≥1.
- `HPIXELS`, 800: pixels per line.
- `VLINES`, 521: lines per frame.
- `HSP`, 96: hsync pulse width in pixels.
- `VSP`, 2: vsync pulse width in lines.
- `HBP`, 144: first visible `hc`.
- `HFP`, 784: first `hc` past the visible area.
- `VBP`, 31: first visible `vc`.
- `VFP`, 511: first `vc` past the visible area.

- `clk` input 1: system clock (50 MHz on board).
- `clr_n` input 1: asynchronous, active-low reset.
- `en` input 1: synchronous run enable. When low, all counters hold.
- `hc` output 10: horizontal counter, range 0..HPIXELS-1.
- `vc` output 10: vertical counter, range 0..VLINES-1.
- `hsync` output 1: active-low; low while `hc < HSP`.
- `vsync` output 1: active-low; low while `vc < VSP`.
- `vidon` output 1: high while `HBP ≤ hc < HFP` and `VBP ≤ vc < VFP`.
- `pix_tick` output 1: one-clk pulse on each cycle where the counters advance.
- `line_start` output 1: one-clk pulse when `hc` wraps to 0.
- `frame_start` output 1: one-clk pulse when `hc` and `vc` both wrap to 0.

## Operation
- The divider counter `div` runs 0..CLK_DIV-1 while `en=1`. The internal tick is asserted when `div==CLK_DIV-1`. With `CLK_DIV=1` the tick is high on every cycle while `en=1`.
- On each tick:
  - If `hc==HPIXELS-1`, then `hc←0`. Also, if `vc==VLINES-1` then `vc←0`, else `vc←vc+1`.
  - Otherwise `hc←hc+1`.
- Sync and window outputs:
  - `hsync`, `vsync` and `vidon` are registered.
  - They are computed from the next-state `hc`/`vc`, so they are always consistent with the `hc`/`vc` values present in the same cycle.
  - Comparisons are unsigned, 10-bit.
- Event pulses:
  - `pix_tick` is registered and asserts in the cycle in which the new `hc` is first visible.
  - `line_start` asserts with the `hc` update to 0.
  - `frame_start` asserts with the `vc` update to 0. It is always coincident with `line_start`.
- When `en=0`:
  - `div`, `hc` and `vc` freeze.
  - `hsync`, `vsync` and `vidon` hold their values.
  - `pix_tick`, `line_start` and `frame_start` are 0.
  - On re-enable, `div` resumes from its held value.
- Reset (`clr_n=0`, asynchronous, any time including mid-line):
  - `div=0`, `hc=0`, `vc=0`.
  - `hsync=0` and `vsync=0` (position 0 is inside both sync pulses).
  - `vidon=0`, `pix_tick=0`, `line_start=0`, `frame_start=0`.
- Release of reset is synchronous to `clk`. The first tick occurs CLK_DIV cycles after release when `en=1`.

## Timing
- Pixel period is CLK_DIV clks: 40 ns at 50 MHz with the defaults.
- Line period is HPIXELS×CLK_DIV clks: 1600 clks.
- Frame period is VLINES×HPIXELS×CLK_DIV clks: 833 600 clks.
- `hc`, `vc` and all outputs change only on the clk edge that follows a tick; latency from tick to output is 1 clk.
- With defaults, per line:
  - `hsync` is low for 96 pixels.
  - `vidon` is high for exactly 640 pixels per visible line.
- With defaults, per frame:
  - `vsync` is low for 2 lines.
  - There are 480 visible lines.
  - There are 307 200 `vidon` pixel-ticks.
- Wrap is simultaneous on both counters at (799, 520) → (0, 0), in one edge. There is no intermediate state in which only one counter has wrapped.

## Test plan
- Reset and release, `en=1`:
  - During reset, all outputs are 0.
  - The first `pix_tick` arrives 2 clks after release, with `hc=1`, `vc=0`.
- Free run for one full frame:
  - Exactly 800 ticks per line and 521 `line_start` pulses between consecutive `frame_start` pulses.
  - Exactly 833 600 clks between consecutive `frame_start` pulses.
- Horizontal boundaries:
  - `hsync` rises when `hc` goes 95→96.
  - `vidon` rises at `hc=144`, `vc=31`, and falls at `hc=784`.
  - `vidon` is never high for `vc` in 0..30 or 511..520.
- Vertical boundaries:
  - `vsync` is low only while `vc∈{0,1}`.
  - Wrap (799, 520)→(0, 0) in one edge, with `line_start`, `frame_start` and `pix_tick` all high together.
- Enable gating:
  - Drop `en` at `hc=300`, `vc=100` for 37 clks.
  - Counters and sync outputs hold and no pulses are emitted.
  - After `en` returns, the next `hc` is 301.
- Asynchronous reset mid-frame:
  - Assert `clr_n=0` between clk edges at `hc=500`, `vc=250`.
  - All outputs go to their reset values immediately, with no clk edge.
  - After release, counting restarts from (0, 0).

Source files
------------

// File: rtl/vga_640x480_timing.sv
// VGA raster timing generator: divides clk to the pixel rate, runs hc/vc,
// and emits registered sync, video window and event pulses aligned to hc/vc.
module vga_640x480_timing #(
  parameter int CLK_DIV = 2,
  parameter int HPIXELS = 800,
  parameter int VLINES  = 521,
  parameter int HSP     = 96,
  parameter int VSP     = 2,
  parameter int HBP     = 144,
  parameter int HFP     = 784,
  parameter int VBP     = 31,
  parameter int VFP     = 511
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       vidon,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(HPIXELS - 1);
  localparam logic [9:0] V_LAST = 10'(VLINES - 1);
  localparam logic [9:0] H_SP   = 10'(HSP);
  localparam logic [9:0] V_SP   = 10'(VSP);
  localparam logic [9:0] H_BP   = 10'(HBP);
  localparam logic [9:0] H_FP   = 10'(HFP);
  localparam logic [9:0] V_BP   = 10'(VBP);
  localparam logic [9:0] V_FP   = 10'(VFP);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [9:0]       hc_reg, hc_next;
  logic [9:0]       vc_reg, vc_next;
  logic             hsync_reg, hsync_next;
  logic             vsync_reg, vsync_next;
  logic             vidon_reg, vidon_next;
  logic             pix_tick_reg, line_start_reg, frame_start_reg;
  logic             tick, line_wrap, frame_wrap;

  always_comb begin
    div_next   = div_reg;
    hc_next    = hc_reg;
    vc_next    = vc_reg;
    tick       = 1'b0;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;

    if (en) begin
      if (div_reg == DIV_LAST) begin
        div_next = '0;
        tick     = 1'b1;
      end else begin
        div_next = div_reg + DIV_W'(1);
      end
    end

    // Both counters wrap on the same edge, so (H_LAST, V_LAST) goes straight to (0, 0).
    if (tick) begin
      if (hc_reg == H_LAST) begin
        hc_next   = '0;
        line_wrap = 1'b1;
        if (vc_reg == V_LAST) begin
          vc_next    = '0;
          frame_wrap = 1'b1;
        end else begin
          vc_next = vc_reg + 10'd1;
        end
      end else begin
        hc_next = hc_reg + 10'd1;
      end
    end

    // Decoded from the next position so the registered flags line up with hc/vc.
    hsync_next = (hc_next >= H_SP);
    vsync_next = (vc_next >= V_SP);
    vidon_next = (hc_next >= H_BP) && (hc_next < H_FP) &&
                 (vc_next >= V_BP) && (vc_next < V_FP);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_reg         <= '0;
      hc_reg          <= '0;
      vc_reg          <= '0;
      hsync_reg       <= 1'b0;
      vsync_reg       <= 1'b0;
      vidon_reg       <= 1'b0;
      pix_tick_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      div_reg         <= div_next;
      hc_reg          <= hc_next;
      vc_reg          <= vc_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      vidon_reg       <= vidon_next;
      pix_tick_reg    <= tick;
      line_start_reg  <= line_wrap;
      frame_start_reg <= frame_wrap;
    end
  end

  assign hc          = hc_reg;
  assign vc          = vc_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign vidon       = vidon_reg;
  assign pix_tick    = pix_tick_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_640x480_timing.sv
// Bench for vga_640x480_timing: a reference derived from the count of enabled
// clocks since reset, with directed boundary, gating and reset phases.
module tb_vga_640x480_timing;

  // Reduced raster so several complete frames fit in a short run.
  localparam int CLK_DIV = 2;
  localparam int HPIXELS = 100;
  localparam int VLINES  = 40;
  localparam int HSP     = 12;
  localparam int VSP     = 2;
  localparam int HBP     = 18;
  localparam int HFP     = 98;
  localparam int VBP     = 5;
  localparam int VFP     = 37;
  localparam int FRAME_CLKS = CLK_DIV * HPIXELS * VLINES;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       en = 1'b0;
  logic [9:0] hc, vc;
  logic       hsync, vsync, vidon, pix_tick, line_start, frame_start;

  always #5 clk = ~clk;

  vga_640x480_timing #(
    .CLK_DIV(CLK_DIV), .HPIXELS(HPIXELS), .VLINES(VLINES),
    .HSP(HSP), .VSP(VSP), .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP)
  ) dut (
    .clk(clk), .clr_n(clr_n), .en(en),
    .hc(hc), .vc(vc), .hsync(hsync), .vsync(vsync), .vidon(vidon),
    .pix_tick(pix_tick), .line_start(line_start), .frame_start(frame_start)
  );

  int      checks = 0;
  int      failures = 0;
  longint  n_en = 0;       // enabled clocks since reset release
  logic    ev_tick = 1'b0; // a pixel boundary was crossed on the last edge
  int      prev_hc = 0, prev_vc = 0;
  logic    prev_hsync = 1'b0, prev_vidon = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      if (failures >= 40) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  task automatic check_model(input string tag);
    int p, eh, ev;
    p  = int'(n_en / CLK_DIV);
    eh = p % HPIXELS;
    ev = (p / HPIXELS) % VLINES;
    check_eq({tag, ".hc"}, 32'(hc), 32'(eh));
    check_eq({tag, ".vc"}, 32'(vc), 32'(ev));
    check_eq({tag, ".hsync"}, 32'(hsync), 32'(eh >= HSP));
    check_eq({tag, ".vsync"}, 32'(vsync), 32'(ev >= VSP));
    check_eq({tag, ".vidon"}, 32'(vidon),
             32'(eh >= HBP && eh < HFP && ev >= VBP && ev < VFP));
    check_eq({tag, ".pix_tick"}, 32'(pix_tick), 32'(ev_tick));
    check_eq({tag, ".line_start"}, 32'(line_start), 32'(ev_tick && eh == 0));
    check_eq({tag, ".frame_start"}, 32'(frame_start), 32'(ev_tick && eh == 0 && ev == 0));
  endtask

  task automatic step();
    prev_hc    = int'(hc);
    prev_vc    = int'(vc);
    prev_hsync = hsync;
    prev_vidon = vidon;
    @(posedge clk);
    if (clr_n && en) n_en++;
    ev_tick = clr_n && en && (n_en % CLK_DIV == 0);
    @(negedge clk);
    check_model("run");
  endtask

  initial begin
    int clks, lines, vid, hlow, hc0, vc0;
    logic hs0, vs0, vd0, found;

    // Reset held with en high
    en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_model("reset");
    end
    clr_n = 1'b1;
    step();
    check_eq("first_tick.early", 32'(pix_tick), 32'd0);
    step();
    check_eq("first_tick.pulse", 32'(pix_tick), 32'd1);
    check_eq("first_tick.hc", 32'(hc), 32'd1);
    check_eq("first_tick.vc", 32'(vc), 32'd0);
    $display("phase reset_release hc=%0d vc=%0d", hc, vc);

    // Free run to the first wrap, then measure one complete frame
    for (int i = 0; i < FRAME_CLKS + 10 && !frame_start; i++) step();
    check_eq("wrap.found", 32'(frame_start), 32'd1);
    check_eq("wrap.prev_hc", 32'(prev_hc), 32'(HPIXELS - 1));
    check_eq("wrap.prev_vc", 32'(prev_vc), 32'(VLINES - 1));
    check_eq("wrap.hc", 32'(hc), 32'd0);
    check_eq("wrap.vc", 32'(vc), 32'd0);
    check_eq("wrap.line_start", 32'(line_start), 32'd1);
    check_eq("wrap.pix_tick", 32'(pix_tick), 32'd1);
    clks = 0; lines = 0; vid = 0; hlow = 0;
    do begin
      lines += int'(line_start);
      if (pix_tick && vidon) vid++;
      if (lines == 1 && pix_tick && !hsync) hlow++;
      step();
      clks++;
      if (!prev_hsync && hsync) check_eq("hsync_rise.hc", 32'(hc), 32'(HSP));
      if (!prev_vidon && vidon) begin
        check_eq("vidon_rise.hc", 32'(hc), 32'(HBP));
        if (vc == 10'(VBP)) check_eq("vidon_rise.first_line", 32'(prev_vc), 32'(VBP));
      end
      if (prev_vidon && !vidon) check_eq("vidon_fall.hc", 32'(hc), 32'(HFP));
    end while (!frame_start && clks <= FRAME_CLKS + 10);
    check_eq("frame.clks", 32'(clks), 32'(FRAME_CLKS));
    check_eq("frame.lines", 32'(lines), 32'(VLINES));
    check_eq("frame.vidon_pixels", 32'(vid), 32'((HFP - HBP) * (VFP - VBP)));
    check_eq("line.hsync_low_pixels", 32'(hlow), 32'(HSP));
    $display("phase free_run clks=%0d lines=%0d vidon_pixels=%0d", clks, lines, vid);

    // Enable gating at a fixed position
    found = 1'b0;
    for (int i = 0; i < FRAME_CLKS + 10 && !found; i++) begin
      step();
      found = (hc == 10'd30 && vc == 10'd10);
    end
    check_eq("gate.found", 32'(found), 32'd1);
    hc0 = int'(hc); vc0 = int'(vc); hs0 = hsync; vs0 = vsync; vd0 = vidon;
    en = 1'b0;
    repeat (37) begin
      step();
      check_eq("gate.hold_hc", 32'(hc), 32'(hc0));
      check_eq("gate.hold_vc", 32'(vc), 32'(vc0));
      check_eq("gate.hold_sync", {30'd0, hsync, vsync}, {30'd0, hs0, vs0});
      check_eq("gate.hold_vidon", 32'(vidon), 32'(vd0));
      check_eq("gate.no_pulse", {29'd0, pix_tick, line_start, frame_start}, 32'd0);
    end
    en = 1'b1;
    for (int i = 0; i < 4 * CLK_DIV && int'(hc) == hc0; i++) step();
    check_eq("gate.resume_hc", 32'(hc), 32'd31);
    $display("phase enable_gate resumed hc=%0d vc=%0d", hc, vc);

    // Asynchronous reset between edges
    found = 1'b0;
    for (int i = 0; i < FRAME_CLKS + 10 && !found; i++) begin
      step();
      found = (hc == 10'd50 && vc == 10'd25);
    end
    check_eq("arst.found", 32'(found), 32'd1);
    #2;
    clr_n = 1'b0;
    #1;
    n_en = 0;
    ev_tick = 1'b0;
    check_eq("arst.hc", 32'(hc), 32'd0);
    check_eq("arst.vc", 32'(vc), 32'd0);
    check_eq("arst.outs", {26'd0, hsync, vsync, vidon, pix_tick, line_start, frame_start}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_model("arst.hold");
    end
    clr_n = 1'b1;
    step();
    step();
    check_eq("arst.restart_hc", 32'(hc), 32'd1);
    check_eq("arst.restart_vc", 32'(vc), 32'd0);
    check_eq("arst.restart_tick", 32'(pix_tick), 32'd1);
    $display("phase async_reset restart hc=%0d vc=%0d", hc, vc);

    // Randomized enable pattern against the reference
    for (int i = 0; i < 6000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      step();
    end
    $display("phase random_enable hc=%0d vc=%0d", hc, vc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
